// File: rtl/prime_mm_pkg.sv
// Shared definitions for the prime datapath MM channel fabric:
// local CSR window offsets, the fabric ID code and a width helper.
package prime_mm_pkg;

  typedef enum logic [1:0] {
    CSR_STATUS = 2'd0,
    CSR_MASK   = 2'd1,
    CSR_CTRL   = 2'd2,
    CSR_ID     = 2'd3
  } csr_off_e;

  localparam logic [15:0] CSR_ID_CODE = 16'h5043;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/prime_mm_irq_agg.sv
// Per-channel completion IRQ capture (STATUS, W1C) with a mask register,
// folded into a single registered interrupt line.
module prime_mm_irq_agg
  import prime_mm_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned IRQ_EDGE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_irq,
  input  logic              status_wr,
  input  logic              mask_wr,
  input  logic [NUM_CH-1:0] wdata,
  output logic [NUM_CH-1:0] status,
  output logic [NUM_CH-1:0] mask,
  output logic              irq
);

  logic [NUM_CH-1:0] irq_q;
  logic [NUM_CH-1:0] set;
  logic [NUM_CH-1:0] clr;

  always_comb begin
    set = (IRQ_EDGE != 0) ? (ch_irq & ~irq_q) : ch_irq;
    clr = status_wr ? wdata : '0;
  end

  // A new event in the same cycle as a W1C keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q  <= '0;
      status <= '0;
      mask   <= '0;
      irq    <= 1'b0;
    end else begin
      irq_q  <= ch_irq;
      status <= (status & ~clr) | set;
      if (mask_wr) mask <= wdata;
      irq    <= |(status & mask);
    end
  end

endmodule

// File: rtl/prime_mm_channel_fabric.sv
// Fans one Avalon-MM bridge master out to NUM_CH prime datapath channels,
// tracking pipelined reads to a single owner channel, plus a local CSR window.
module prime_mm_channel_fabric
  import prime_mm_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CH_ADDR_BITS = 9,
  parameter int unsigned MAX_PENDING  = 4,
  parameter int unsigned IRQ_EDGE     = 1,
  localparam int unsigned SEL_W  = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH),
  localparam int unsigned ADDR_W = 1 + SEL_W + CH_ADDR_BITS
) (
  input  logic                           sys_clk_in,
  input  logic                           sys_reset_in,
  input  logic [ADDR_W-1:0]              IMC_mm_address_in,
  input  logic [DATA_W-1:0]              IMC_mm_writedata_in,
  input  logic                           IMC_mm_write_in,
  input  logic                           IMC_mm_read_in,
  output logic                           IMC_mm_waitrequest_out,
  output logic [DATA_W-1:0]              IMC_mm_readdata_out,
  output logic                           IMC_mm_readdatavalid_out,
  output logic [NUM_CH*CH_ADDR_BITS-1:0] ch_mm_address_out,
  output logic [NUM_CH*DATA_W-1:0]       ch_mm_writedata_out,
  output logic [NUM_CH-1:0]              ch_mm_write_out,
  output logic [NUM_CH-1:0]              ch_mm_read_out,
  input  logic [NUM_CH-1:0]              ch_mm_waitrequest_in,
  input  logic [NUM_CH*DATA_W-1:0]       ch_mm_readdata_in,
  input  logic [NUM_CH-1:0]              ch_mm_readdatavalid_in,
  input  logic [NUM_CH-1:0]              ch_irq_in,
  output logic                           irq_out
);

  localparam int unsigned PEND_W = clog2(MAX_PENDING) + 1;

  logic                    csr_sel;
  logic [SEL_W-1:0]        sel;
  logic [CH_ADDR_BITS-1:0] offset;
  logic [NUM_CH-1:0]       hit;
  logic [NUM_CH-1:0]       owner_hot;
  logic                    mapped, sel_wait, owner_valid, busy, full;
  logic                    stall, wait_req, rd_acc, csr_rd_acc, csr_wr, good_ret, stray;
  logic [DATA_W-1:0]       owner_data;
  logic [DATA_W-1:0]       csr_word;
  logic [PEND_W-1:0]       pending;
  logic [SEL_W-1:0]        owner;
  logic                    err;
  logic                    csr_valid;
  logic [DATA_W-1:0]       csr_rdata;
  logic [NUM_CH-1:0]       status, mask;

  assign csr_sel = IMC_mm_address_in[ADDR_W-1];
  assign sel     = IMC_mm_address_in[CH_ADDR_BITS +: SEL_W];
  assign offset  = IMC_mm_address_in[CH_ADDR_BITS-1:0];

  // One-hot decode avoids a range compare that is constant for power-of-2 NUM_CH.
  always_comb begin
    hit         = '0;
    owner_hot   = '0;
    sel_wait    = 1'b0;
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i]       = !csr_sel && (sel == SEL_W'(i));
      owner_hot[i] = (owner == SEL_W'(i));
      sel_wait     = sel_wait | (hit[i] & ch_mm_waitrequest_in[i]);
      if (owner_hot[i]) begin
        owner_valid = ch_mm_readdatavalid_in[i];
        owner_data  = ch_mm_readdata_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    mapped     = |hit;
    busy       = (pending != '0);
    full       = (pending == PEND_W'(MAX_PENDING));
    stall      = IMC_mm_read_in & busy & (!mapped | (sel != owner) | full);
    wait_req   = sel_wait | stall;
    rd_acc     = IMC_mm_read_in & mapped & !wait_req;
    csr_rd_acc = IMC_mm_read_in & !mapped & !wait_req;
    csr_wr     = IMC_mm_write_in & csr_sel & !wait_req;
    good_ret   = owner_valid & busy;
    stray      = (|(ch_mm_readdatavalid_in & ~owner_hot)) | (owner_valid & !busy);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_mm_write_out[i] = IMC_mm_write_in & hit[i];
      ch_mm_read_out[i]  = IMC_mm_read_in & hit[i] & !stall;
      ch_mm_address_out[i*CH_ADDR_BITS +: CH_ADDR_BITS] = hit[i] ? offset : '0;
      ch_mm_writedata_out[i*DATA_W +: DATA_W] = hit[i] ? IMC_mm_writedata_in : '0;
    end
  end

  always_comb begin
    csr_word = '0;
    if (csr_sel) begin
      case (csr_off_e'(offset[1:0]))
        CSR_STATUS: csr_word[NUM_CH-1:0] = status;
        CSR_MASK:   csr_word[NUM_CH-1:0] = mask;
        CSR_CTRL: begin
          csr_word[PEND_W-1:0] = pending;
          csr_word[DATA_W-1]   = err;
        end
        CSR_ID:     csr_word = DATA_W'({CSR_ID_CODE, 16'(NUM_CH)});
        default:    csr_word = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk_in) begin
    if (sys_reset_in) begin
      pending   <= '0;
      owner     <= '0;
      err       <= 1'b0;
      csr_valid <= 1'b0;
      csr_rdata <= '0;
    end else begin
      case ({rd_acc, good_ret})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
      if (rd_acc) owner <= sel;
      if (stray)
        err <= 1'b1;
      else if (csr_wr && offset[1:0] == CSR_CTRL && IMC_mm_writedata_in[DATA_W-1])
        err <= 1'b0;
      csr_valid <= csr_rd_acc;
      csr_rdata <= csr_rd_acc ? csr_word : '0;
    end
  end

  assign IMC_mm_waitrequest_out   = wait_req;
  assign IMC_mm_readdatavalid_out = csr_valid | good_ret;
  assign IMC_mm_readdata_out      = csr_valid ? csr_rdata : (good_ret ? owner_data : '0);

  prime_mm_irq_agg #(
    .NUM_CH   (NUM_CH),
    .IRQ_EDGE (IRQ_EDGE)
  ) u_irq_agg (
    .clk       (sys_clk_in),
    .rst       (sys_reset_in),
    .ch_irq    (ch_irq_in),
    .status_wr (csr_wr && offset[1:0] == CSR_STATUS),
    .mask_wr   (csr_wr && offset[1:0] == CSR_MASK),
    .wdata     (IMC_mm_writedata_in[NUM_CH-1:0]),
    .status    (status),
    .mask      (mask),
    .irq       (irq_out)
  );

endmodule

// File: tb/tb_prime_mm_channel_fabric.sv
// Directed bench for prime_mm_channel_fabric: a 4-channel fabric with a
// latency-programmable channel responder, plus a 5-channel one for unmapped selects.
module tb_prime_mm_channel_fabric;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AB  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [11:0]       addr;
  logic [31:0]       wdata;
  logic              wr, rd;
  logic              waitreq, rdv, irq;
  logic [31:0]       rdata;
  logic [NCH*AB-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata, ch_rdata;
  logic [NCH-1:0]    ch_wr, ch_rd, ch_wait, ch_valid, ch_irq;

  logic [12:0]  addr5;
  logic         wr5, rd5, wait5, rdv5, irq5;
  logic [31:0]  rdata5;
  logic [44:0]  ch_addr5;
  logic [159:0] ch_wdata5;
  logic [4:0]   ch_wr5, ch_rd5;
  logic [4:0]   zero5;
  logic [159:0] zero5w;

  int errors = 0;
  int checks = 0;

  logic        pv [NCH][8];
  logic [31:0] pd [NCH][8];
  int          lat [NCH];

  prime_mm_channel_fabric #(
    .NUM_CH(4), .DATA_W(32), .CH_ADDR_BITS(9), .MAX_PENDING(4), .IRQ_EDGE(1)
  ) u_dut (
    .sys_clk_in(clk), .sys_reset_in(rst),
    .IMC_mm_address_in(addr), .IMC_mm_writedata_in(wdata),
    .IMC_mm_write_in(wr), .IMC_mm_read_in(rd),
    .IMC_mm_waitrequest_out(waitreq), .IMC_mm_readdata_out(rdata),
    .IMC_mm_readdatavalid_out(rdv),
    .ch_mm_address_out(ch_addr), .ch_mm_writedata_out(ch_wdata),
    .ch_mm_write_out(ch_wr), .ch_mm_read_out(ch_rd),
    .ch_mm_waitrequest_in(ch_wait), .ch_mm_readdata_in(ch_rdata),
    .ch_mm_readdatavalid_in(ch_valid), .ch_irq_in(ch_irq),
    .irq_out(irq)
  );

  prime_mm_channel_fabric #(
    .NUM_CH(5), .DATA_W(32), .CH_ADDR_BITS(9), .MAX_PENDING(4), .IRQ_EDGE(1)
  ) u_dut5 (
    .sys_clk_in(clk), .sys_reset_in(rst),
    .IMC_mm_address_in(addr5), .IMC_mm_writedata_in(wdata),
    .IMC_mm_write_in(wr5), .IMC_mm_read_in(rd5),
    .IMC_mm_waitrequest_out(wait5), .IMC_mm_readdata_out(rdata5),
    .IMC_mm_readdatavalid_out(rdv5),
    .ch_mm_address_out(ch_addr5), .ch_mm_writedata_out(ch_wdata5),
    .ch_mm_write_out(ch_wr5), .ch_mm_read_out(ch_rd5),
    .ch_mm_waitrequest_in(zero5), .ch_mm_readdata_in(zero5w),
    .ch_mm_readdatavalid_in(zero5), .ch_irq_in(zero5),
    .irq_out(irq5)
  );

  function automatic logic [31:0] exp_data(input int c, input int off);
    return 32'hA000_0000 | (32'(c) << 16) | 32'(off);
  endfunction

  // Channel responder: valid appears lat[c] cycles after the accepting cycle.
  initial begin
    for (int c = 0; c < NCH; c++) begin
      lat[c] = 1;
      for (int k = 0; k < 8; k++) begin
        pv[c][k] = 1'b0;
        pd[c][k] = '0;
      end
    end
    ch_valid = '0;
    ch_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < 7; k++) begin
          pv[c][k] = pv[c][k+1];
          pd[c][k] = pd[c][k+1];
        end
        pv[c][7] = 1'b0;
        if (ch_rd[c] && !ch_wait[c]) begin
          pv[c][lat[c]] = 1'b1;
          pd[c][lat[c]] = exp_data(c, int'(ch_addr[c*AB +: AB]));
        end
        ch_valid[c] = pv[c][0];
        ch_rdata[c*DW +: DW] = pv[c][0] ? pd[c][0] : '0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_read(input logic [1:0] off, output logic [31:0] d, output logic v);
    addr = 12'h800 | 12'(off);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    @(negedge clk);
    d = rdata;
    v = rdv;
    tick();
  endtask

  task automatic csr_write(input logic [1:0] off, input logic [31:0] d);
    addr  = 12'h800 | 12'(off);
    wdata = d;
    wr    = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic v;
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (waitreq !== 1'b0) begin errors++; $display("FAIL reset_wait got=%b exp=0", waitreq); end
    checks++; if (rdv !== 1'b0) begin errors++; $display("FAIL reset_rdv got=%b exp=0", rdv); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if ({ch_wr, ch_rd} !== 8'h00) begin errors++; $display("FAIL reset_strobes got=%h exp=00", {ch_wr, ch_rd}); end
    tick();
    rst = 1'b0;
    csr_read(2'd2, d, v);
    checks++; if ({v, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL reset_ctrl got=%b/%h exp=1/00000000", v, d); end
    csr_read(2'd1, d, v);
    checks++; if ({v, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL reset_mask got=%b/%h exp=1/00000000", v, d); end
  endtask

  task automatic test_write;
    addr  = {1'b0, 2'd2, 9'd5};
    wdata = 32'h11;
    wr    = 1'b1;
    @(negedge clk);
    checks++; if (ch_wr !== 4'b0100) begin errors++; $display("FAIL wr_strobe got=%b exp=0100", ch_wr); end
    checks++; if (ch_rd !== 4'b0000) begin errors++; $display("FAIL wr_rd_idle got=%b exp=0000", ch_rd); end
    checks++; if (ch_addr[2*AB +: AB] !== 9'd5) begin errors++; $display("FAIL wr_addr got=%0d exp=5", ch_addr[2*AB +: AB]); end
    checks++; if (ch_wdata[2*DW +: DW] !== 32'h11) begin errors++; $display("FAIL wr_data got=%h exp=00000011", ch_wdata[2*DW +: DW]); end
    checks++; if (waitreq !== 1'b0) begin errors++; $display("FAIL wr_wait got=%b exp=0", waitreq); end
    tick();
    wr = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic v;
    logic ew, ev;
    int eoff;
    lat[1] = 4;
    for (int k = 0; k < 10; k++) begin
      rd   = (k <= 5);
      addr = {1'b0, 2'd1, 9'(k < 4 ? k : 4)};
      ew   = (k == 4);
      ev   = (k >= 4 && k <= 7) || k == 9;
      eoff = (k < 8) ? k - 4 : 4;
      @(negedge clk);
      if (k <= 5) begin
        checks++; if (waitreq !== ew) begin errors++; $display("FAIL b2b_wait[%0d] got=%b exp=%b", k, waitreq, ew); end
        checks++; if (ch_rd !== (ew ? 4'b0000 : 4'b0010)) begin errors++; $display("FAIL b2b_chrd[%0d] got=%b exp=%b", k, ch_rd, ew ? 4'b0000 : 4'b0010); end
      end
      checks++; if (rdv !== ev) begin errors++; $display("FAIL b2b_rdv[%0d] got=%b exp=%b", k, rdv, ev); end
      if (ev) begin
        checks++; if (rdata !== exp_data(1, eoff)) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, rdata, exp_data(1, eoff)); end
      end
      tick();
    end
    csr_read(2'd2, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL b2b_pending_end got=%h exp=00000000", d); end
  endtask

  task automatic test_switch;
    logic ew, ev;
    logic [3:0] erd;
    lat[0] = 2;
    lat[3] = 1;
    for (int k = 0; k < 5; k++) begin
      rd   = (k < 4);
      addr = (k == 0) ? {1'b0, 2'd0, 9'd7} : {1'b0, 2'd3, 9'd1};
      ew   = (k == 1 || k == 2);
      ev   = (k == 2 || k == 4);
      erd  = (k == 0) ? 4'b0001 : (k == 3) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (k < 4) begin
        checks++; if (waitreq !== ew) begin errors++; $display("FAIL sw_wait[%0d] got=%b exp=%b", k, waitreq, ew); end
        checks++; if (ch_rd !== erd) begin errors++; $display("FAIL sw_chrd[%0d] got=%b exp=%b", k, ch_rd, erd); end
      end
      checks++; if (rdv !== ev) begin errors++; $display("FAIL sw_rdv[%0d] got=%b exp=%b", k, rdv, ev); end
      if (k == 2) begin
        checks++; if (rdata !== exp_data(0, 7)) begin errors++; $display("FAIL sw_data0 got=%h exp=%h", rdata, exp_data(0, 7)); end
      end
      if (k == 4) begin
        checks++; if (rdata !== exp_data(3, 1)) begin errors++; $display("FAIL sw_data3 got=%h exp=%h", rdata, exp_data(3, 1)); end
      end
      tick();
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic v;
    csr_write(2'd1, 32'h2);
    ch_irq = 4'b0010;
    tick();
    ch_irq = 4'b0000;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq); end
    tick();
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got=%b exp=1", irq); end
    tick();
    csr_read(2'd0, d, v);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL irq_status got=%h exp=00000002", d); end
    ch_irq = 4'b0010;
    csr_write(2'd0, 32'h2);
    csr_read(2'd0, d, v);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL irq_set_wins got=%h exp=00000002", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_held got=%b exp=1", irq); end
    csr_write(2'd0, 32'h2);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_clr_lag got=%b exp=1", irq); end
    tick();
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert got=%b exp=0", irq); end
    tick();
    ch_irq = 4'b0000;
    csr_read(2'd0, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_status_clr got=%h exp=00000000", d); end
  endtask

  task automatic test_csr_id;
    logic [31:0] d;
    logic v;
    csr_read(2'd3, d, v);
    checks++; if ({v, d} !== {1'b1, 32'h5043_0004}) begin errors++; $display("FAIL id4 got=%b/%h exp=1/50430004", v, d); end
  endtask

  task automatic test_unmapped;
    addr5 = {1'b0, 3'd5, 9'd3};
    rd5 = 1'b1;
    @(negedge clk);
    checks++; if (wait5 !== 1'b0) begin errors++; $display("FAIL unm_wait got=%b exp=0", wait5); end
    checks++; if (ch_rd5 !== 5'b0) begin errors++; $display("FAIL unm_chrd got=%b exp=00000", ch_rd5); end
    tick();
    rd5 = 1'b0;
    @(negedge clk);
    checks++; if ({rdv5, rdata5} !== {1'b1, 32'h0}) begin errors++; $display("FAIL unm_read got=%b/%h exp=1/00000000", rdv5, rdata5); end
    tick();
    addr5 = 13'h1003;
    rd5 = 1'b1;
    tick();
    rd5 = 1'b0;
    @(negedge clk);
    checks++; if ({rdv5, rdata5} !== {1'b1, 32'h5043_0005}) begin errors++; $display("FAIL id5 got=%b/%h exp=1/50430005", rdv5, rdata5); end
    tick();
    addr5 = {1'b0, 3'd5, 9'd3};
    wdata = 32'hDEAD;
    wr5 = 1'b1;
    @(negedge clk);
    checks++; if ({wait5, ch_wr5} !== 6'b0) begin errors++; $display("FAIL unm_write got=%b/%b exp=0/00000", wait5, ch_wr5); end
    tick();
    wr5 = 1'b0;
  endtask

  task automatic test_reset_midflight;
    logic [31:0] d;
    logic v;
    lat[1] = 6;
    rd = 1'b1;
    addr = {1'b0, 2'd1, 9'h10};
    tick();
    addr = {1'b0, 2'd1, 9'h11};
    tick();
    rd  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    csr_read(2'd2, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_pending got=%h exp=00000000", d); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (rdv !== 1'b0) begin errors++; $display("FAIL mid_drop[%0d] got=%b exp=0", j, rdv); end
      tick();
    end
    csr_read(2'd2, d, v);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL mid_err got=%h exp=80000000", d); end
    csr_write(2'd2, 32'h8000_0000);
    csr_read(2'd2, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_err_clr got=%h exp=00000000", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0;
    ch_wait = '0; ch_irq = '0;
    addr5 = '0; wr5 = 1'b0; rd5 = 1'b0; zero5 = '0; zero5w = '0;
    test_reset();
    test_write();
    test_back_to_back();
    test_switch();
    test_irq();
    test_csr_id();
    test_unmapped();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
